// File: rtl/myadder1_example_pkg.sv
// Shared types and constants for the myadder1 example AXI4-Stream path.
package myadder1_example_pkg;

  localparam int AXIS_DW      = 512;
  localparam int AXIS_KW      = AXIS_DW / 8;
  localparam int C_STAT_WIDTH = 32;

  // One AXI4-Stream beat at the default path width.
  typedef struct packed {
    logic [AXIS_DW-1:0] tdata;
    logic [AXIS_KW-1:0] tkeep;
    logic               tlast;
  } axis_beat_t;

endpackage

// File: rtl/myadder1_example_axis_packetizer_if.sv
// AXI4-Stream bundle used on both sides of the packetizer.
interface myadder1_example_axis_packetizer_if #(
  parameter int C_AXIS_TDATA_WIDTH = 512
);
  logic                            tvalid;
  logic                            tready;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] tkeep;
  logic                            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/myadder1_example_axis_out_reg.sv
// Output register stage with valid/ready. Holds its contents while the
// consumer stalls; only accepts a load when it is free this cycle.
module myadder1_example_axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         free,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign free = !out_valid || out_ready;

  // Load on a free slot, otherwise retire the beat once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load && free) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/myadder1_example_axis_packetizer.sv
// Re-frames the result stream into C2H packets. tlast is generated every
// ctrl_pkt_beats beats, on an input tlast, or after ctrl_timeout idle cycles.
// A one-beat hold register keeps each beat until its tlast is known.
// Optional: define MYADDER1_PKTZ_STATS_EN for packet / flush counters.
module myadder1_example_axis_packetizer
  import myadder1_example_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_PKT_CNT_WIDTH    = 16,
  parameter int C_TIMEOUT_WIDTH    = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [C_PKT_CNT_WIDTH-1:0] ctrl_pkt_beats,
  input  logic [C_TIMEOUT_WIDTH-1:0] ctrl_timeout,
  myadder1_example_axis_packetizer_if.slave  s_axis,
  myadder1_example_axis_packetizer_if.master m_axis,
  output logic [C_STAT_WIDTH-1:0]    stat_pkt_count,
  output logic [C_STAT_WIDTH-1:0]    stat_flush_count
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int PW = C_PKT_CNT_WIDTH;
  localparam int TW = C_TIMEOUT_WIDTH;
  localparam int OW = DW + KW + 1;

  logic [DW-1:0] h_data;
  logic [KW-1:0] h_keep;
  logic          h_last;
  logic          h_valid;
  logic [PW-1:0] beat_cnt;
  logic [PW-1:0] pkt_len;
  logic [TW-1:0] idle_cnt;

  logic          o_free;
  logic          h_final;
  logic          timeout_hit;
  logic          h_drain;
  logic          s_fire;
  logic          drain_tlast;
  logic          pkt_start;
  logic [OW-1:0] o_data;

  assign h_final     = h_last || (pkt_len != '0 && beat_cnt == pkt_len - PW'(1));
  assign timeout_hit = (ctrl_timeout != '0) && (idle_cnt >= ctrl_timeout - TW'(1));
  // A new beat arriving forces the held beat out, so s_tvalid stands in for
  // s_fire here; that breaks the tready -> drain -> tready loop.
  assign h_drain     = h_valid && o_free && (h_final || s_axis.tvalid || timeout_hit);
  assign s_axis.tready = aresetn && (!h_valid || h_drain);
  assign s_fire      = s_axis.tvalid && s_axis.tready;
  // A successor arriving in the same cycle cancels the timeout flush.
  assign drain_tlast = h_final || (timeout_hit && !s_fire);
  // The entering beat opens a packet when H is empty at a boundary or the
  // beat it replaces closes one; this covers back-to-back packets too.
  assign pkt_start   = s_fire && (h_valid ? drain_tlast : (beat_cnt == '0));

  // Hold register: capture every accepted beat, empty it on a drain.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_valid <= 1'b0;
      h_data  <= '0;
      h_keep  <= '0;
      h_last  <= 1'b0;
    end else if (s_fire) begin
      h_valid <= 1'b1;
      h_data  <= s_axis.tdata;
      h_keep  <= s_axis.tkeep;
      h_last  <= s_axis.tlast;
    end else if (h_drain) begin
      h_valid <= 1'b0;
    end
  end

  // Position within the packet and packet length latched at packet start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt <= '0;
      pkt_len  <= '0;
    end else begin
      if (h_drain) beat_cnt <= drain_tlast ? '0 : beat_cnt + PW'(1);
      if (pkt_start) pkt_len <= ctrl_pkt_beats;
    end
  end

  // Idle cycles with a beat parked in H; saturates so a long stall cannot wrap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_cnt <= '0;
    end else if (s_fire || !h_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  myadder1_example_axis_out_reg #(.W(OW)) u_out_reg (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (h_drain),
    .load_data ({h_data, h_keep, drain_tlast}),
    .free      (o_free),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (o_data)
  );

  assign m_axis.tdata = o_data[OW-1 -: DW];
  assign m_axis.tkeep = o_data[KW:1];
  assign m_axis.tlast = o_data[0];

`ifdef MYADDER1_PKTZ_STATS_EN
  logic [C_STAT_WIDTH-1:0] pkt_cnt_q;
  logic [C_STAT_WIDTH-1:0] flush_cnt_q;

  // Count delivered packets and drains forced purely by the idle timeout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (h_drain && timeout_hit && !h_final && !s_fire) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stat_pkt_count   = pkt_cnt_q;
  assign stat_flush_count = flush_cnt_q;
`else
  assign stat_pkt_count   = '0;
  assign stat_flush_count = '0;
`endif

endmodule

// File: tb/tb_myadder1_example_axis_packetizer.sv
// Bench for the packetizer: table of packet scenarios plus hand-written
// sequences, with a scoreboard queue checked at the output.
module tb_myadder1_example_axis_packetizer;
  import myadder1_example_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] ctrl_pkt_beats = '0;
  logic [15:0] ctrl_timeout = '0;
  logic [31:0] stat_pkt_count, stat_flush_count;

  myadder1_example_axis_packetizer_if #(.C_AXIS_TDATA_WIDTH(AXIS_DW)) s_if ();
  myadder1_example_axis_packetizer_if #(.C_AXIS_TDATA_WIDTH(AXIS_DW)) m_if ();

  myadder1_example_axis_packetizer #(
    .C_AXIS_TDATA_WIDTH(AXIS_DW), .C_PKT_CNT_WIDTH(16), .C_TIMEOUT_WIDTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctrl_pkt_beats(ctrl_pkt_beats), .ctrl_timeout(ctrl_timeout),
    .s_axis(s_if), .m_axis(m_if),
    .stat_pkt_count(stat_pkt_count), .stat_flush_count(stat_flush_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          pkt;
    int          to;
    int          nb;
    int          last_at;   // index carrying input tlast, -1 none
    int          rmode;     // 0 ready, 1 toggle, 2 random
    int          vmode;     // 1 = random input gaps
    int          flush_to;  // timeout applied after the stream to flush a held beat
    logic [31:0] exp_mask;  // expected output tlast per beat
    int          exp_flush;
  } vec_t;

  vec_t       tv[8];
  axis_beat_t sb[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int rmode = 0;
  int exp_pkt = 0, exp_flush = 0;
  int fire_first = -1, out_first = -1, out_last = -1;

  initial forever begin @(posedge aclk); cyc++; end

  // Output ready pattern.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (rmode)
        0: m_if.tready = 1'b1;
        1: m_if.tready = !m_if.tready;
        2: m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop and stall stability.
  initial begin
    logic stall;
    axis_beat_t saved, e;
    stall = 1'b0;
    saved = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_vec++;
          if (!m_if.tvalid || m_if.tdata != saved.tdata || m_if.tkeep != saved.tkeep ||
              m_if.tlast != saved.tlast) begin
            n_err++;
            $display("FAIL stall_stable: got v=%0b d=%h l=%0b, want held d=%h l=%0b",
                     m_if.tvalid, m_if.tdata[31:0], m_if.tlast, saved.tdata[31:0], saved.tlast);
          end
        end
        if (m_if.tvalid && m_if.tready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got d=%h l=%0b, want nothing", m_if.tdata[31:0], m_if.tlast);
          end else begin
            e = sb.pop_front();
            if (m_if.tdata != e.tdata || m_if.tkeep != e.tkeep || m_if.tlast != e.tlast) begin
              n_err++;
              $display("FAIL out_beat: got d=%h k=%h l=%0b, want d=%h k=%h l=%0b",
                       m_if.tdata[31:0], m_if.tkeep, m_if.tlast, e.tdata[31:0], e.tkeep, e.tlast);
            end
          end
          if (out_first < 0) out_first = cyc;
          out_last = cyc;
        end
        stall = m_if.tvalid && !m_if.tready;
        saved = '{tdata: m_if.tdata, tkeep: m_if.tkeep, tlast: m_if.tlast};
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Drive one beat; called at posedge+1, returns at posedge+1 after it fires.
  task automatic send(input int t, input int b, input logic l, input logic el);
    logic [AXIS_DW-1:0] d;
    logic [AXIS_KW-1:0] k;
    int w;
    d = {16{32'(t * 1000 + b)}} ^ {AXIS_DW{1'b0}};
    k = {$urandom, $urandom};
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
    w = 0;
    forever begin
      @(negedge aclk);
      if (s_if.tready) break;
      w++;
      if (w > 300) begin
        n_vec++; n_err++;
        $display("FAIL send_wait: tready never seen for test %0d beat %0d", t, b);
        $fatal(1, "input stuck");
      end
    end
    sb.push_back('{tdata: d, tkeep: k, tlast: el});
    if (fire_first < 0) fire_first = cyc;
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic wait_empty(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin @(negedge aclk); w++; end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
    @(posedge aclk); #1;
  endtask

  task automatic check_stats(input string name);
`ifdef MYADDER1_PKTZ_STATS_EN
    check({name, "_pkt_count"}, stat_pkt_count, exp_pkt);
    check({name, "_flush_count"}, stat_flush_count, exp_flush);
`else
    check({name, "_pkt_count"}, stat_pkt_count, 0);
    check({name, "_flush_count"}, stat_flush_count, 0);
`endif
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;

    tv[0] = '{pkt: 4, to: 0,  nb: 12, last_at: -1, rmode: 0, vmode: 0, flush_to: 0, exp_mask: 32'h888, exp_flush: 0};
    tv[1] = '{pkt: 8, to: 10, nb: 3,  last_at: -1, rmode: 0, vmode: 0, flush_to: 0, exp_mask: 32'h4,   exp_flush: 1};
    tv[2] = '{pkt: 4, to: 0,  nb: 16, last_at: -1, rmode: 1, vmode: 0, flush_to: 0, exp_mask: 32'h8888, exp_flush: 0};
    tv[3] = '{pkt: 0, to: 0,  nb: 6,  last_at: 4,  rmode: 0, vmode: 0, flush_to: 3, exp_mask: 32'h30,  exp_flush: 1};
    tv[4] = '{pkt: 1, to: 0,  nb: 3,  last_at: -1, rmode: 0, vmode: 0, flush_to: 0, exp_mask: 32'h7,   exp_flush: 0};
    tv[5] = '{pkt: 3, to: 0,  nb: 5,  last_at: 1,  rmode: 0, vmode: 0, flush_to: 0, exp_mask: 32'h12,  exp_flush: 0};
    tv[6] = '{pkt: 4, to: 0,  nb: 8,  last_at: -1, rmode: 2, vmode: 0, flush_to: 0, exp_mask: 32'h88,  exp_flush: 0};
    tv[7] = '{pkt: 5, to: 0,  nb: 10, last_at: -1, rmode: 0, vmode: 1, flush_to: 0, exp_mask: 32'h210, exp_flush: 0};

    // Reset state.
    repeat (3) @(posedge aclk);
    #3;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_m_tdata", m_if.tdata[63:0], 0);
    check_stats("rst");
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 8; i++) begin
      ctrl_pkt_beats = 16'(tv[i].pkt);
      ctrl_timeout   = 16'(tv[i].to);
      rmode          = tv[i].rmode;
      fire_first = -1; out_first = -1; out_last = -1;
      idle(1);
      for (int b = 0; b < tv[i].nb; b++) begin
        send(i, b, (b == tv[i].last_at), tv[i].exp_mask[b]);
        if (tv[i].vmode != 0) idle($urandom_range(0, 2));
      end
      if (tv[i].flush_to != 0) begin
        idle(8);
        check($sformatf("t%0d_held_beat", i), sb.size(), 1);
        ctrl_timeout = 16'(tv[i].flush_to);
      end
      wait_empty($sformatf("t%0d", i));
      exp_pkt   += $countones(tv[i].exp_mask);
      exp_flush += tv[i].exp_flush;
      if (i == 0) begin
        check("t0_first_latency", out_first - fire_first, 2);
        check("t0_no_gaps", out_last - out_first, 11);
      end
    end
    check_stats("table");

    // Packet length changed mid-packet: current packet keeps 4, next uses 2.
    rmode = 0; ctrl_timeout = 0; ctrl_pkt_beats = 16'd4;
    idle(1);
    send(20, 0, 1'b0, 1'b0);
    send(20, 1, 1'b0, 1'b0);
    ctrl_pkt_beats = 16'd2;
    send(20, 2, 1'b0, 1'b0);
    send(20, 3, 1'b0, 1'b1);
    send(20, 4, 1'b0, 1'b0);
    send(20, 5, 1'b0, 1'b1);
    send(20, 6, 1'b0, 1'b0);
    send(20, 7, 1'b0, 1'b1);
    wait_empty("len_change");
    exp_pkt += 3;

    // Timeout while the output is blocked: flush waits, tlast still forced.
    ctrl_pkt_beats = 16'd8; ctrl_timeout = 16'd4; rmode = 3;
    idle(2);
    send(21, 0, 1'b0, 1'b0);
    send(21, 1, 1'b0, 1'b1);
    idle(15);
    check("blocked_nothing_out", sb.size(), 2);
    rmode = 0;
    wait_empty("blocked_flush");
    exp_pkt += 1; exp_flush += 1;
    check_stats("blocked");

    // Reset with H and O both full.
    ctrl_timeout = 0; rmode = 3;
    idle(2);
    send(22, 0, 1'b0, 1'b0);
    send(22, 1, 1'b0, 1'b0);
    idle(2);
    check("prerst_m_tvalid", m_if.tvalid, 1);
    s_if.tvalid = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_s_tready", s_if.tready, 0);
    s_if.tvalid = 1'b0;
    sb.delete();
    exp_pkt = 0; exp_flush = 0;
    check_stats("midrst");
    @(negedge aclk); @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    rmode = 0; ctrl_pkt_beats = 16'd2;
    idle(1);
    for (int b = 0; b < 4; b++) send(23, b, 1'b0, 1'(b % 2));
    wait_empty("post_rst");
    exp_pkt += 2;
    check_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
